// File: rtl/decoder_select_arbiter.sv
// Round-robin arbiter that shares one 2x4 decoder among four requesters, with a dead gap between grants.
// Optional feature macro: HOLD_LIMIT_EN (forced release after MAX_HOLD grant cycles).
module decoder_select_arbiter #(
  parameter int IDLE_GAP = 1,
  parameter int MAX_HOLD = 8
) (
  input  logic       Clock,
  input  logic       Reset_b,
  input  logic [3:0] req,
  output logic       A,
  output logic       B,
  output logic       enable,
  output logic [3:0] gnt,
  output logic       busy,
  output logic       preempt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  if (IDLE_GAP < 1 || IDLE_GAP > 15) begin : g_badGap
    $error("IDLE_GAP must be in 1..15");
  end
  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_badHold
    $error("MAX_HOLD must be in 1..255");
  end

  state_t     r_state;
  logic [1:0] r_lastPtr;
  logic [3:0] r_gapCnt;
  logic       r_a;
  logic       r_b;
  logic       r_enable;
  logic [3:0] r_gnt;
  logic       r_busy;
  logic       r_preempt;
`ifdef HOLD_LIMIT_EN
  logic [7:0] r_holdCnt;
`endif

  logic       w_anyReq;
  logic [1:0] w_winner;
  logic [1:0] w_cand;
  logic [1:0] w_owner;

  assign A       = r_a;
  assign B       = r_b;
  assign enable  = r_enable;
  assign gnt     = r_gnt;
  assign busy    = r_busy;
  assign preempt = r_preempt;
  assign w_owner = {r_a, r_b};

  // Scan from lowest to highest priority so the last hit (offset 1 past the pointer) wins.
  always_comb begin
    w_anyReq = |req;
    w_winner = r_lastPtr;
    w_cand   = r_lastPtr;
    for (int k = 4; k >= 1; k--) begin
      w_cand = r_lastPtr + 2'(k);
      if (req[w_cand]) w_winner = w_cand;
    end
  end

  always_ff @(posedge Clock or negedge Reset_b) begin
    if (!Reset_b) begin
      r_state   <= IDLE;
      r_lastPtr <= 2'd3;
      r_gapCnt  <= 4'd0;
      r_a       <= 1'b0;
      r_b       <= 1'b0;
      r_enable  <= 1'b1;
      r_gnt     <= 4'b0000;
      r_busy    <= 1'b0;
      r_preempt <= 1'b0;
`ifdef HOLD_LIMIT_EN
      r_holdCnt <= 8'd0;
`endif
    end else begin
      r_preempt <= 1'b0;
      case (r_state)
        IDLE: begin
          r_gapCnt <= 4'd0;
          if (w_anyReq) begin
            r_state   <= GRANT;
            r_lastPtr <= w_winner;
            {r_a, r_b} <= w_winner;
            r_enable  <= 1'b0;
            r_gnt     <= 4'b0001 << w_winner;
            r_busy    <= 1'b1;
`ifdef HOLD_LIMIT_EN
            r_holdCnt <= 8'd1;
`endif
          end
        end
        GRANT: begin
          // A normal drop takes precedence over a hold-limit expiry on the same edge.
          if (!req[w_owner]) begin
            r_state  <= GAP;
            r_enable <= 1'b1;
            r_gnt    <= 4'b0000;
            r_gapCnt <= 4'd1;
`ifdef HOLD_LIMIT_EN
          end else if (r_holdCnt == 8'(MAX_HOLD)) begin
            r_state   <= GAP;
            r_enable  <= 1'b1;
            r_gnt     <= 4'b0000;
            r_gapCnt  <= 4'd1;
            r_preempt <= 1'b1;
          end else begin
            r_holdCnt <= r_holdCnt + 8'd1;
`endif
          end
        end
        GAP: begin
          if (r_gapCnt == 4'(IDLE_GAP)) begin
            if (w_anyReq) begin
              r_state   <= GRANT;
              r_lastPtr <= w_winner;
              {r_a, r_b} <= w_winner;
              r_enable  <= 1'b0;
              r_gnt     <= 4'b0001 << w_winner;
`ifdef HOLD_LIMIT_EN
              r_holdCnt <= 8'd1;
`endif
            end else begin
              r_state  <= IDLE;
              r_busy   <= 1'b0;
              r_gapCnt <= 4'd0;
            end
          end else begin
            r_gapCnt <= r_gapCnt + 4'd1;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_enable <= 1'b1;
          r_gnt    <= 4'b0000;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decoder_select_arbiter.sv
// Directed-vector bench for decoder_select_arbiter (default parameters IDLE_GAP=1, MAX_HOLD=8).
module tb_decoder_select_arbiter;

  logic       Clock = 1'b0;
  logic       Reset_b;
  logic [3:0] req;
  logic       A, B, enable, busy, preempt;
  logic [3:0] gnt;

  int checks = 0;
  int failures = 0;

  decoder_select_arbiter dut (
    .Clock   (Clock),
    .Reset_b (Reset_b),
    .req     (req),
    .A       (A),
    .B       (B),
    .enable  (enable),
    .gnt     (gnt),
    .busy    (busy),
    .preempt (preempt)
  );

  always #5 Clock = ~Clock;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic applyStimulus();
    @(posedge Clock);
    #1;
  endtask

  task automatic resetDut();
    @(negedge Clock);
    Reset_b = 1'b0;
    #2;
    Reset_b = 1'b1;
  endtask

  // Packs {A,B,enable,gnt,busy} for compact comparisons.
  function automatic logic [31:0] outVec();
    return {24'd0, A, B, enable, gnt, busy};
  endfunction

  initial begin
    Reset_b = 1'b1;
    req = 4'b0000;

    // Reset takes effect without a clock edge.
    #2 Reset_b = 1'b0;
    #1;
    checkOutput("reset_outs", outVec(), {24'd0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0});
    checkOutput("reset_preempt", {31'd0, preempt}, 32'd0);
    @(negedge Clock);
    Reset_b = 1'b1;

    // Single requester 2.
    applyStimulus();
    req = 4'b0100;
    applyStimulus();
    checkOutput("single_grant", outVec(), {24'd0, 1'b1, 1'b0, 1'b0, 4'b0100, 1'b1});
    req = 4'b0000;
    applyStimulus();
    checkOutput("single_gap", outVec(), {24'd0, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b1});
    applyStimulus();
    checkOutput("single_idle", outVec(), {24'd0, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b0});

    // Pointer now 2: req=0011 skips empty 3 and wraps to 0, then 1.
    req = 4'b0011;
    applyStimulus();
    checkOutput("wrap_grant0", outVec(), {24'd0, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b1});
    req = 4'b0010;
    applyStimulus();
    checkOutput("wrap_gap", outVec(), {24'd0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b1});
    applyStimulus();
    checkOutput("wrap_grant1", outVec(), {24'd0, 1'b0, 1'b1, 1'b0, 4'b0010, 1'b1});
    req = 4'b0000;
    applyStimulus();
    applyStimulus();
    checkOutput("wrap_idle", {31'd0, busy}, 32'd0);

    // Round robin with all four requesting; each owner holds two cycles then re-raises.
    resetDut();
    applyStimulus();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      logic [3:0] expGnt;
      expGnt = 4'b0001 << (k % 4);
      applyStimulus();
      checkOutput($sformatf("rr_grant%0d_c1", k), {28'd0, gnt}, {28'd0, expGnt});
      checkOutput($sformatf("rr_sel%0d", k), {30'd0, A, B}, 32'(k % 4));
      applyStimulus();
      checkOutput($sformatf("rr_grant%0d_c2", k), {27'd0, enable, gnt}, {27'd0, 1'b0, expGnt});
      req = req & ~expGnt;
      applyStimulus();
      checkOutput($sformatf("rr_gap%0d", k), {26'd0, enable, gnt, busy}, {26'd0, 1'b1, 4'b0000, 1'b1});
      req = req | expGnt;
    end
    req = 4'b0000;
    applyStimulus();
    checkOutput("rr_idle", {31'd0, busy}, 32'd0);

    // Hold behaviour with req=0011 held.
    resetDut();
    req = 4'b0011;
`ifdef HOLD_LIMIT_EN
    for (int c = 0; c < 8; c++) applyStimulus();
    checkOutput("hold_last_cycle", {28'd0, gnt}, 32'b0001);
    applyStimulus();
    checkOutput("hold_preempt", {26'd0, preempt, enable, gnt}, {26'd0, 1'b1, 1'b1, 4'b0000});
    applyStimulus();
    checkOutput("hold_next", {27'd0, preempt, gnt}, {27'd0, 1'b0, 4'b0010});
`else
    for (int c = 0; c < 12; c++) applyStimulus();
    checkOutput("hold_kept", {27'd0, preempt, gnt}, {27'd0, 1'b0, 4'b0001});
    req = 4'b0010;
    applyStimulus();
    checkOutput("hold_release", {27'd0, enable, gnt}, {27'd0, 1'b1, 4'b0000});
    applyStimulus();
    checkOutput("hold_next", {27'd0, preempt, gnt}, {27'd0, 1'b0, 4'b0010});
`endif
    req = 4'b0000;
    applyStimulus();
    applyStimulus();

    // Reset in the middle of grant 2 clears outputs at once and restores the pointer.
    req = 4'b0100;
    applyStimulus();
    checkOutput("mid_grant2", {28'd0, gnt}, 32'b0100);
    Reset_b = 1'b0;
    #1;
    checkOutput("mid_reset", outVec(), {24'd0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0});
    req = 4'b0101;
    Reset_b = 1'b1;
    applyStimulus();
    checkOutput("post_reset_grant0", outVec(), {24'd0, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b1});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
